// File: rtl/ex_mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 opcodes, FSM states
// and operand-signedness helpers.
package ex_mdu_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op1_signed(input mdu_op_e op);
        return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic op2_signed(input mdu_op_e op);
        return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_mdu_sign_fix.sv
// Conditional two's-complement negate: gives |x| when neg is the sign bit,
// and re-applies the result sign at completion.
module ex_mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Optional MDU_FAST_MUL_EN: multiplies complete in one cycle through a full-width multiplier.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      f3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state;
    mdu_op_e           op_in;
    mdu_op_e           op_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  cnt;
    logic              s1;
    logic              s2;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;
    logic [XLEN-1:0]   op1_abs;
    logic [XLEN-1:0]   op2_abs;
    logic [XLEN-1:0]   fast_res;
    logic              in_s1;
    logic              in_s2;
    logic              div_zero;
    logic              div_ovf;
    logic              fast_hit;

    assign op_in   = mdu_op_e'(f3_i);
    assign in_s1   = op1_signed(op_in) & op1_i[XLEN-1];
    assign in_s2   = op2_signed(op_in) & op2_i[XLEN-1];
    assign busy_o  = (state == MDU_CALC);
    assign ready_o = (state == MDU_IDLE) || (state == MDU_DONE);

    ex_mdu_sign_fix #(.W(XLEN))   u_abs1    (.val(op1_i), .neg(in_s1), .res(op1_abs));
    ex_mdu_sign_fix #(.W(XLEN))   u_abs2    (.val(op2_i), .neg(in_s2), .res(op2_abs));
    ex_mdu_sign_fix #(.W(2*XLEN)) u_fix_prd (.val(step_next), .neg(s1 ^ s2), .res(prod_fix));
    ex_mdu_sign_fix #(.W(XLEN))   u_fix_quo (.val(step_next[XLEN-1:0]), .neg(s1 ^ s2), .res(quo_fix));
    ex_mdu_sign_fix #(.W(XLEN))   u_fix_rem (.val(step_next[2*XLEN-1:XLEN]), .neg(s1), .res(rem_fix));

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN:0] mul_full;
    assign mul_full = {{(XLEN+1){in_s1}}, op1_i} * {{(XLEN+1){in_s2}}, op2_i};
`endif

    // Requests that never need the iterative datapath, resolved at accept time.
    always_comb begin
        div_zero = is_div(op_in) && (op2_i == '0);
        div_ovf  = ((op_in == F3_DIV) || (op_in == F3_REM)) && (op1_i == MIN_VAL) && (op2_i == '1);
        fast_hit = div_zero || div_ovf;
        fast_res = '0;
        if (div_zero)
            fast_res = op_in[1] ? op1_i : '1;
        else if (div_ovf)
            fast_res = op_in[1] ? '0 : MIN_VAL;
`ifdef MDU_FAST_MUL_EN
        if (!is_div(op_in)) begin
            fast_hit = 1'b1;
            fast_res = (op_in == F3_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end
`endif
    end

    // prod holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_abs} : '0);
        div_diff = prod[2*XLEN-1:XLEN-1] - {1'b0, b_abs};
        if (is_div(op_q))
            step_next = div_diff[XLEN] ? {prod[2*XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
        else
            step_next = {mul_sum, prod[XLEN-1:1]};
    end

    always_comb begin
        case (op_q)
            F3_MUL:                         final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   final_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                final_res = quo_fix;
            default:                        final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MDU_IDLE;
            result_o <= '0;
            rd_o     <= '0;
            done_o   <= 1'b0;
            cnt      <= '0;
            op_q     <= F3_MUL;
            rd_q     <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            a_abs    <= '0;
            b_abs    <= '0;
            prod     <= '0;
        end else if (flush_i) begin
            state  <= MDU_IDLE;
            done_o <= 1'b0;
            cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                MDU_IDLE, MDU_DONE: begin
                    if (valid_i) begin
                        op_q  <= op_in;
                        rd_q  <= rd_i;
                        s1    <= in_s1;
                        s2    <= in_s2;
                        a_abs <= op1_abs;
                        b_abs <= op2_abs;
                        cnt   <= '0;
                        prod  <= {{XLEN{1'b0}}, is_div(op_in) ? op1_abs : op2_abs};
                        if (fast_hit) begin
                            result_o <= fast_res;
                            rd_o     <= rd_i;
                            done_o   <= 1'b1;
                            state    <= MDU_DONE;
                        end else begin
                            state <= MDU_CALC;
                        end
                    end else begin
                        state <= MDU_IDLE;
                    end
                end
                MDU_CALC: begin
                    prod <= step_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result_o <= final_res;
                        rd_o     <= rd_q;
                        done_o   <= 1'b1;
                        cnt      <= '0;
                        state    <= MDU_DONE;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (XLEN=32): directed vector table, random ops against
// an arithmetic reference model, and flush / back-to-back / reset sequences.
module tb_ex_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_i = 1'b0;
    logic [2:0]      f3_i = '0;
    logic [XLEN-1:0] op1_i = '0;
    logic [XLEN-1:0] op2_i = '0;
    logic [4:0]      rd_i = '0;
    logic            flush_i = 1'b0;
    logic            ready_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    ex_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .f3_i(f3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_i(rd_i), .flush_i(flush_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    // Reference model straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint p;
        logic [31:0] r;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f3[2])
            return 1;
`endif
        return XLEN + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done_o; returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit no_wait,
                                 output int lat, output logic [31:0] res, output logic [4:0] rdo,
                                 output int busy_bad);
        if (!no_wait) @(negedge clk);
        valid_i = 1'b1; f3_i = f3; op1_i = a; op2_i = b; rd_i = rd;
        @(posedge clk);
        lat = -1; res = '0; rdo = '0; busy_bad = 0;
        for (int c = 1; c <= XLEN + 5; c++) begin
            @(negedge clk);
            if (c == 1) valid_i = 1'b0;
            if (done_o) begin
                lat = c; res = result_o; rdo = rd_o;
                break;
            end
            if (!busy_o) busy_bad++;
        end
    endtask

    initial begin
        int lat, busy_bad, done_seen;
        logic [31:0] res, last_exp, ra, rb;
        logic [4:0]  rdo;
        logic [2:0]  rf;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_result", result_o, 0);
        checkOutput("rst_rd", rd_o, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0, lat, res, rdo, busy_bad);
            checkOutput($sformatf("tbl%0d_result", i), res, vecs[i].exp);
            checkOutput($sformatf("tbl%0d_latency", i), lat, exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b));
            checkOutput($sformatf("tbl%0d_rd", i), rdo, 5'(i + 1));
            checkOutput($sformatf("tbl%0d_busy", i), busy_bad, 0);
        end

        last_exp = '0;
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            applyStimulus(rf, ra, rb, 5'(n), 1'b0, lat, res, rdo, busy_bad);
            last_exp = ref_mdu(rf, ra, rb);
            checkOutput($sformatf("rnd%0d_f3=%0d_result", n, rf), res, last_exp);
            checkOutput($sformatf("rnd%0d_latency", n), lat, exp_lat(rf, ra, rb));
        end

        // Flush mid-divide, with a competing request in the flush cycle.
        @(negedge clk);
        valid_i = 1'b1; f3_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3; rd_i = 5'd5;
        @(posedge clk);
        done_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) valid_i = 1'b0;
            if (done_o) done_seen++;
        end
        flush_i = 1'b1; valid_i = 1'b1; f3_i = 3'd0; op1_i = 32'd7; op2_i = 32'hFFFF_FFFD; rd_i = 5'd6;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        checkOutput("flush_busy", busy_o, 0);
        checkOutput("flush_ready", ready_o, 1);
        checkOutput("flush_done", done_o, 0);
        checkOutput("flush_no_done_before", done_seen, 0);
        checkOutput("flush_result_held", result_o, last_exp);
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd6, 1'b1, lat, res, rdo, busy_bad);
        checkOutput("post_flush_result", res, 32'hFFFF_FFEB);
        checkOutput("post_flush_rd", rdo, 6);
        checkOutput("post_flush_latency", lat, exp_lat(3'd0, 32'd7, 32'hFFFF_FFFD));

        // Back-to-back: second request presented during the DONE cycle.
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd3, 1'b0, lat, res, rdo, busy_bad);
        checkOutput("b2b_first_result", res, 14);
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd4, 1'b1, lat, res, rdo, busy_bad);
        checkOutput("b2b_second_result", res, 32'hFFFF_FFEB);
        checkOutput("b2b_second_rd", rdo, 4);
        checkOutput("b2b_second_latency", lat, exp_lat(3'd0, 32'd7, 32'hFFFF_FFFD));

        // Reset in the middle of a divide.
        @(negedge clk);
        valid_i = 1'b1; f3_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd7; rd_i = 5'd9;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        checkOutput("pre_rst_busy", busy_o, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_ready", ready_o, 1);
        checkOutput("mid_rst_busy", busy_o, 0);
        checkOutput("mid_rst_done", done_o, 0);
        checkOutput("mid_rst_result", result_o, 0);
        done_seen = 0;
        repeat (XLEN + 4) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        checkOutput("mid_rst_discarded", done_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Iterative multiply/divide unit implementing the RV32M/RV64M funct3 operation set. It sits beside the single-cycle ALU in the execute stage. It takes already-forwarded operands, runs one shift-add or restoring-subtract step per cycle, and returns the result with the destination tag through a valid/done handshake. The hazard unit stalls the pipeline while busy_o is high.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN), iteration counter width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_i  in  1  request; accepted only when ready_o=1
f3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  in  XLEN  rs1 value (forwarded)
op2_i  in  XLEN  rs2 value (forwarded)
rd_i  in  5  destination register tag
flush_i  in  1  abort current operation (branch mispredict/trap)
ready_o  out  1  can accept a request (state IDLE or DONE)
busy_o  out  1  operation in flight (state CALC)
done_o  out  1  one-cycle pulse: result_o/rd_o valid
result_o  out  XLEN  result; held until the next accept
rd_o  out  5  tag of the completed operation

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset puts the FSM in IDLE and clears all of the following: result_o=0, rd_o=0, done_o=0, busy_o=0, ready_o=1, counter=0.
- Accept: on the edge where valid_i & ready_o & !flush_i, latch f3_i, rd_i, the sign flags, and the absolute operand values. Sign rules:
  - signed: MULH, DIV and REM use both operands signed; MULHSU uses op1 signed only.
  - unsigned: MUL, MULHU, DIVU and REMU.
- Multiply path: 2*XLEN product register, one shift-add step per cycle.
- Divide path: restoring division, one quotient bit per cycle.
- CALC lasts exactly XLEN cycles with counter 0..XLEN-1. On the last iteration edge, apply sign correction, load result_o, and go to DONE.
- Latency: request sampled at edge 0 gives done_o=1 during cycle XLEN+1.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - Product sign is negated when the operand signs differ (signed ops only).
  - Quotient sign = s1^s2; remainder sign = s1.
- Fast path, decided at accept, skips CALC and goes straight to DONE (done_o in cycle 1):
  - divide by zero: quotient = all ones, remainder = op1.
  - signed overflow (op1 = MIN, op2 = -1) for DIV/REM: quotient = MIN, remainder = 0.
- DONE lasts one cycle with done_o=1. In that cycle ready_o=1, so a back-to-back accept is allowed (DONE->CALC). Otherwise DONE->IDLE.
- valid_i while busy_o=1 is ignored, with no queueing. The issuer must hold the request.
- flush_i, synchronous, any state: next state IDLE, done_o=0, result_o unchanged, counter cleared. If flush_i and valid_i arrive in the same cycle, flush wins and the request is not accepted.
- rst mid-operation: same as the reset values above; the in-flight result is discarded.
- busy_o = (state==CALC). ready_o = (state==IDLE || state==DONE).

Optional Feature:
MDU_FAST_MUL_EN
- Defined: multiplies use a registered full-width multiplier (MUL* accept -> DONE in 1 cycle, done_o in cycle 1). Divides are unchanged.
- Undefined: multiplies use the iterative XLEN-cycle path. Port list is identical either way.

Decomposition:
- Shared header (define.v): F3_MUL..F3_REMU constants, MDU_IDLE/MDU_CALC/MDU_DONE state encodings, XLEN-independent bus macros.
- One natural sub-module, mdu_sign_fix: combinational abs/negate, parametrised on XLEN. It is used at accept (abs) and at completion (negate).

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32) -> result_o=0xFFFFFFEB, done_o high in cycle 33, busy_o high cycles 1-32.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. All complete with done_o in cycle 1.
- DIVU issued, flush_i at cycle 10 -> busy_o=0 from cycle 11, no done_o; a new MUL accepted at cycle 11 completes normally with its own rd_o.
- Back-to-back: second valid_i during DONE accepted; rst asserted mid-CALC -> ready_o=1, done_o=0 next cycle. Repeat the MUL case with MDU_FAST_MUL_EN defined -> done_o in cycle 1.
